// File: rtl/axi_read_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_master_if
//  Description : Bundle of every bus that axi_read_master talks on. It covers
//                the loader request, the downstream data queue, the
//                completion response, and the AXI4 AR and R channels.
//                The master modport is the read master's view. The slave
//                modport is the view of everything around it (loader, queue,
//                interconnect).
//  Ports       : req_*         request in (valid/ready, address, ARLEN-coded len)
//                data_queue_*  beat push out, with queue ready in
//                resp_*        completion out (valid/ready, error flag)
//                axi_ar*       AXI4 read-address channel
//                axi_r*        AXI4 read-data channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_read_master_if #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);
  // request
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_start_address;
  logic [7:0]            req_len;
  // downstream data queue
  logic                  data_queue_push;
  logic                  data_queue_ready;
  logic [DATA_WIDTH-1:0] data_queue_data;
  // completion
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_error;
  // AXI AR channel
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [1:0]            axi_arburst;
  logic [3:0]            axi_arcache;
  logic [ID_WIDTH-1:0]   axi_arid;
  logic [7:0]            axi_arlen;
  logic                  axi_arlock;
  logic [2:0]            axi_arprot;
  logic [3:0]            axi_arqos;
  logic [2:0]            axi_arsize;
  logic                  axi_arvalid;
  logic                  axi_arready;
  // AXI R channel
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [ID_WIDTH-1:0]   axi_rid;
  logic                  axi_rlast;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    input  req_valid, req_start_address, req_len,
    output req_ready,
    output data_queue_push, data_queue_data,
    input  data_queue_ready,
    output resp_valid, resp_error,
    input  resp_ready,
    output axi_araddr, axi_arburst, axi_arcache, axi_arid, axi_arlen,
           axi_arlock, axi_arprot, axi_arqos, axi_arsize, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rid, axi_rlast, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    output req_valid, req_start_address, req_len,
    input  req_ready,
    input  data_queue_push, data_queue_data,
    output data_queue_ready,
    input  resp_valid, resp_error,
    output resp_ready,
    input  axi_araddr, axi_arburst, axi_arcache, axi_arid, axi_arlen,
           axi_arlock, axi_arprot, axi_arqos, axi_arsize, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rid, axi_rlast, axi_rresp, axi_rvalid,
    input  axi_rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_read_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_master
//  Description : AXI4 read-only burst initiator. It takes one (address, len)
//                request and issues a single INCR burst on AR. It streams
//                the returned R beats straight into the downstream data queue
//                and then reports completion with a sticky error flag.
//                Only one burst is in flight at a time.
//  Ports       : core_clk  clock, rising edge
//                rst       synchronous active-high reset
//                bus       axi_read_master_if.master (request, data queue,
//                          response, AXI AR/R)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_master #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  wire logic              core_clk,
  input  wire logic              rst,
  axi_read_master_if.master      bus
);

  localparam logic [2:0]          c_arsize = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0] c_axi_id = ID_WIDTH'(AXI_ID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_count;
  logic                  r_error;

  logic                  w_req_hs;
  logic                  w_r_hs;
  logic                  w_beat_err;
  logic                  w_count_at_len;

  assign w_req_hs       = bus.req_valid && bus.req_ready;
  assign w_r_hs         = bus.axi_rvalid && bus.axi_rready;
  assign w_count_at_len = (r_count == r_len);

  // A beat is bad if the slave flags it, if it carries a foreign ID, or if
  // RLAST does not line up with the beat count we asked for.
  assign w_beat_err = (bus.axi_rresp != 2'b00)
                   || (bus.axi_rid != c_axi_id)
                   || ( bus.axi_rlast && !w_count_at_len)
                   || (!bus.axi_rlast &&  w_count_at_len);

  // AR payload comes from the registered request, so it stays stable while
  // ARVALID waits for ARREADY.
  assign bus.axi_araddr  = r_addr;
  assign bus.axi_arlen   = r_len;
  assign bus.axi_arburst = 2'b01;
  assign bus.axi_arsize  = c_arsize;
  assign bus.axi_arid    = c_axi_id;
  assign bus.axi_arcache = 4'b0000;
  assign bus.axi_arlock  = 1'b0;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_arqos   = 4'b0000;

  assign bus.data_queue_data = bus.axi_rdata;

  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_req_hs) begin
        r_addr  <= bus.req_start_address;
        r_len   <= bus.req_len;
        r_count <= '0;
        r_error <= 1'b0;
      end
      if (w_r_hs) begin
        // Saturate at len. An overlong burst then keeps flagging "late
        // last" until RLAST finally arrives.
        if (!w_count_at_len) begin
          r_count <= r_count + 8'd1;
        end
        if (w_beat_err) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next        = r_state;
    bus.req_ready       = 1'b0;
    bus.axi_arvalid     = 1'b0;
    bus.axi_rready      = 1'b0;
    bus.data_queue_push = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = S_AR;
        end
      end
      S_AR: begin
        bus.axi_arvalid = 1'b1;
        if (bus.axi_arready) begin
          w_state_next = S_R;
        end
      end
      S_R: begin
        // Gate RREADY on queue space so a beat is accepted only when it
        // can be pushed in the same cycle.
        bus.axi_rready      = bus.data_queue_ready;
        bus.data_queue_push = bus.axi_rvalid && bus.data_queue_ready;
        if (bus.axi_rvalid && bus.data_queue_ready && bus.axi_rlast) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = r_error;
        if (bus.resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_master
//  Description : Directed, table-driven bench for axi_read_master. Each
//                table row is one burst: the request, the AR delay, the
//                queue-ready and rvalid patterns, the error injection, the
//                response backpressure and the expected error flag.
//                A hand-written sequence covers reset in the middle of a
//                burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_master;

  localparam int AW = 34;
  localparam int DW = 512;
  localparam int IW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            nbeats;      // beats the slave returns (rlast on the last)
    int            err_kind;    // 0 none, 1 rresp=SLVERR on err_beat, 2 rid=5
    int            err_beat;
    int            ar_delay;    // cycles arvalid waits before arready
    logic [3:0]    qpat;        // data_queue_ready, bit = cycle mod 4
    logic [3:0]    rvpat;       // axi_rvalid, bit = cycle mod 4
    int            resp_delay;  // extra cycles resp_ready stays low
    logic          exp_err;
  } vec_t;

  logic core_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 core_clk = ~core_clk;

  axi_read_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_read_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0)
  ) dut (
    .core_clk (core_clk),
    .rst      (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int mon_pushes = 0;

  always @(posedge core_clk) begin
    if (bus.data_queue_push) mon_pushes <= mon_pushes + 1;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int vi, input int b);
    logic [DW-1:0] d;
    d = {64{8'hA5}};
    d[31:0]    = d[31:0] ^ {vi[7:0], b[23:0]};
    d[511:480] = d[511:480] ^ b;
    return d;
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int  b;
    int  c;
    int  start_pushes;
    bit  done;
    logic qr;
    logic rv;
    // request
    @(negedge core_clk);
    bus.req_valid         = 1'b1;
    bus.req_start_address = v.addr;
    bus.req_len           = v.len;
    #1;
    chk("req_ready_idle", bus.req_ready, 1'b1);
    chk("arvalid_not_same_cycle", bus.axi_arvalid, 1'b0);
    // AR phase: a stray rvalid here must not be consumed
    for (int k = 0; k <= v.ar_delay; k++) begin
      @(negedge core_clk);
      bus.req_valid         = 1'b0;
      bus.req_start_address = '1;
      bus.req_len           = 8'hFF;
      bus.axi_arready       = (k == v.ar_delay);
      bus.axi_rvalid        = 1'b1;
      bus.axi_rdata         = '1;
      bus.axi_rlast         = 1'b1;
      bus.data_queue_ready  = 1'b1;
      #1;
      chk("arvalid", bus.axi_arvalid, 1'b1);
      chk("araddr", bus.axi_araddr, v.addr);
      chk("arlen", bus.axi_arlen, v.len);
      chk("ar_fixed_fields",
          {bus.axi_arsize, bus.axi_arburst, bus.axi_arid, bus.axi_arcache,
           bus.axi_arlock, bus.axi_arprot, bus.axi_arqos},
          {3'd6, 2'b01, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0});
      chk("rready_outside_r", bus.axi_rready, 1'b0);
      chk("push_outside_r", bus.data_queue_push, 1'b0);
      chk("req_ready_busy", bus.req_ready, 1'b0);
    end
    // R phase
    start_pushes = mon_pushes;
    b = 0;
    c = 0;
    done = 1'b0;
    while (!done && c < 600) begin
      @(negedge core_clk);
      bus.axi_arready      = 1'b0;
      qr = v.qpat[c % 4];
      rv = v.rvpat[c % 4];
      bus.data_queue_ready = qr;
      bus.axi_rvalid       = rv;
      bus.axi_rdata        = beat_data(vi, b);
      bus.axi_rlast        = (b == v.nbeats - 1);
      bus.axi_rresp        = (v.err_kind == 1 && b == v.err_beat) ? 2'b10 : 2'b00;
      bus.axi_rid          = (v.err_kind == 2) ? 4'd5 : 4'd0;
      #1;
      chk("rready", bus.axi_rready, qr);
      chk("push", bus.data_queue_push, rv && qr);
      chk("resp_valid_during_r", bus.resp_valid, 1'b0);
      if (rv && qr) begin
        chk("push_data", bus.data_queue_data, beat_data(vi, b));
        if (b == v.nbeats - 1) done = 1'b1;
        b++;
      end
      c++;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL r_phase_timeout actual=%0d beats required=%0d", b, v.nbeats);
    end
    // response phase
    @(negedge core_clk);
    bus.axi_rvalid       = 1'b0;
    bus.axi_rlast        = 1'b0;
    bus.axi_rresp        = 2'b00;
    bus.axi_rid          = '0;
    bus.data_queue_ready = 1'b1;
    #1;
    chk("push_count", 32'(mon_pushes - start_pushes), 32'(v.nbeats));
    chk("resp_valid", bus.resp_valid, 1'b1);
    chk("resp_error", bus.resp_error, v.exp_err);
    chk("req_ready_in_resp", bus.req_ready, 1'b0);
    chk("rready_in_resp", bus.axi_rready, 1'b0);
    for (int k = 0; k < v.resp_delay; k++) begin
      @(negedge core_clk);
      bus.req_valid         = 1'b1;
      bus.req_start_address = 34'h0_0000_9000;
      bus.req_len           = 8'd1;
      #1;
      chk("resp_valid_hold", bus.resp_valid, 1'b1);
      chk("resp_error_hold", bus.resp_error, v.exp_err);
      chk("req_ignored", bus.req_ready, 1'b0);
      chk("arvalid_in_resp", bus.axi_arvalid, 1'b0);
    end
    @(negedge core_clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    chk("resp_valid_at_hs", bus.resp_valid, 1'b1);
    @(negedge core_clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("resp_valid_after", bus.resp_valid, 1'b0);
    chk("resp_error_after", bus.resp_error, 1'b0);
    chk("req_ready_after", bus.req_ready, 1'b1);
    chk("arvalid_after", bus.axi_arvalid, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{34'h0_0000_1000, 8'd0,   1,   0, 0, 0, 4'b1111, 4'b1111, 0, 1'b0};
    vecs[1] = '{34'h2_0000_0040, 8'd3,   4,   0, 0, 3, 4'b0101, 4'b1111, 0, 1'b0};
    vecs[2] = '{34'h0_0000_3000, 8'd3,   4,   1, 2, 0, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[3] = '{34'h0_0000_4000, 8'd3,   2,   0, 0, 1, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[4] = '{34'h0_0000_5000, 8'd3,   4,   2, 0, 0, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[5] = '{34'h0_0000_6000, 8'd1,   3,   0, 0, 0, 4'b1111, 4'b1111, 0, 1'b1};
    vecs[6] = '{34'h3_FFFF_0000, 8'd255, 256, 0, 0, 0, 4'b1111, 4'b1111, 0, 1'b0};
    vecs[7] = '{34'h0_0000_7000, 8'd2,   3,   0, 0, 2, 4'b1110, 4'b1011, 5, 1'b0};
    vecs[8] = '{34'h1_2345_6780, 8'd2,   3,   0, 0, 1, 4'b1111, 4'b1111, 2, 1'b0};

    bus.req_valid         = 1'b0;
    bus.req_start_address = '0;
    bus.req_len           = '0;
    bus.data_queue_ready  = 1'b0;
    bus.resp_ready        = 1'b0;
    bus.axi_arready       = 1'b0;
    bus.axi_rdata         = '0;
    bus.axi_rid           = '0;
    bus.axi_rlast         = 1'b0;
    bus.axi_rresp         = 2'b00;
    bus.axi_rvalid        = 1'b0;

    repeat (3) @(negedge core_clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_arvalid", bus.axi_arvalid, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_araddr", bus.axi_araddr, '0);
    chk("rst_arlen", bus.axi_arlen, '0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of an 8-beat burst, after two beats.
    @(negedge core_clk);
    bus.req_valid         = 1'b1;
    bus.req_start_address = 34'h0_0000_8000;
    bus.req_len           = 8'd7;
    @(negedge core_clk);
    bus.req_valid   = 1'b0;
    bus.axi_arready = 1'b1;
    @(negedge core_clk);
    bus.axi_arready      = 1'b0;
    bus.data_queue_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.axi_rvalid = 1'b1;
      bus.axi_rdata  = beat_data(20, k);
      bus.axi_rlast  = 1'b0;
      #1;
      chk("mid_burst_push", bus.data_queue_push, 1'b1);
      @(negedge core_clk);
    end
    bus.axi_rdata = beat_data(20, 2);
    rst = 1'b1;
    @(negedge core_clk);
    rst = 1'b0;
    #1;
    chk("mrst_req_ready", bus.req_ready, 1'b1);
    chk("mrst_arvalid", bus.axi_arvalid, 1'b0);
    chk("mrst_rready", bus.axi_rready, 1'b0);
    chk("mrst_push", bus.data_queue_push, 1'b0);
    chk("mrst_resp_valid", bus.resp_valid, 1'b0);
    chk("mrst_resp_error", bus.resp_error, 1'b0);
    chk("mrst_araddr", bus.axi_araddr, '0);
    chk("mrst_arlen", bus.axi_arlen, '0);
    bus.axi_rvalid = 1'b0;
    run_vec(vecs[8], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- AXI4 read-only burst initiator.
- Accepts a (start address, length) request, issues one INCR burst on AR, and streams the returned R beats into a downstream data queue.
- Reports completion, with an error flag, on a valid/ready response channel.
- Read-side counterpart of the team's AXI write master; sits between compute-side loaders and the AXI interconnect.

Parameters:
- ADDR_WIDTH, 34, AXI address width.
- DATA_WIDTH, 512, AXI data width in bits; power of two, 8..1024.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ARID driven on every burst; returned RID must match.

Ports:
- core_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request.
- req_start_address  in  ADDR_WIDTH  burst start byte address.
- req_len  in  8  beats minus one (AXI ARLEN encoding).
- data_queue_push  out  1  write one beat into the downstream queue.
- data_queue_ready  in  1  queue can accept a beat this cycle.
- data_queue_data  out  DATA_WIDTH  beat payload (RDATA).
- resp_valid  out  1  burst complete.
- resp_ready  in  1  consumer accepts the completion.
- resp_error  out  1  burst had an error; qualified by resp_valid.
- axi_araddr, axi_arburst(2), axi_arcache(4), axi_arid(ID_WIDTH), axi_arlen(8), axi_arlock(1), axi_arprot(3), axi_arqos(4), axi_arsize(3), axi_arvalid(1)  out  AXI AR channel.
- axi_arready  in  1  AXI AR channel.
- axi_rdata(DATA_WIDTH), axi_rid(ID_WIDTH), axi_rlast(1), axi_rresp(2), axi_rvalid(1)  in  AXI R channel.
- axi_rready  out  1  AXI R channel.

Behaviour:
- FSM states:
  - IDLE: req_ready=1. On req_valid && req_ready, register address and length, clear beat counter and error flag, go to AR.
  - AR: axi_arvalid=1. On axi_arready, go to R.
  - R: handle R beats (see R channel rules). On a handshake with axi_rlast=1, go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- Latency: request accepted in cycle N gives ARVALID in cycle N+1. An AR handshake in cycle M allows RREADY no earlier than M+1. A completing last beat in cycle K gives resp_valid in K+1. Earliest next request acceptance is the cycle after the resp handshake; no back-to-back or outstanding bursts.
- AR fields:
  - araddr and arlen come from the registered request and are stable while arvalid is high.
  - arburst=2'b01 (INCR); arsize=log2(DATA_WIDTH/8), i.e. 3'b110 at 512.
  - arid=AXI_ID; arcache, arlock, arprot, arqos all 0.
- R channel:
  - axi_rready = (state==R) && data_queue_ready.
  - data_queue_push = axi_rvalid && axi_rready, same cycle.
  - data_queue_data = axi_rdata, combinational.
  - No beat is dropped or duplicated under any rvalid/ready pattern.
- Beat counter: 8 bits, increments on each R handshake.
- Error flag is sticky for the burst and is set by an R handshake with any of:
  - rresp != 2'b00;
  - rid != AXI_ID;
  - rlast=1 while counter != registered len (early last);
  - rlast=0 while counter == registered len (late last; counter saturates at len, keep accepting beats until rlast).
- resp_error equals the flag while resp_valid=1 and is 0 otherwise. resp_valid and resp_error hold stable until resp_ready.
- len=0: single beat; rlast is expected on beat 0.
- A request presented while not in IDLE is ignored; req_ready=0 outside IDLE.
- rvalid while not in R: rready=0 and no push. The block does not consume the beat.
- Reset: synchronous, takes priority over all other events, and may be applied mid-burst.
  - Values after the reset edge: state IDLE, req_ready=1, axi_arvalid=0, axi_rready=0, data_queue_push=0, resp_valid=0, resp_error=0, counter=0, registered address/len=0.
  - A burst in flight at reset is abandoned; the interconnect must be reset alongside.

Test Plan:
- Single beat: req addr=0x0_0000_1000, len=0; arready on first arvalid cycle; one beat rdata=0xA5.., rlast=1, rresp=0 -> araddr=0x1000, arlen=0, arsize=6, arburst=1; one push of 0xA5..; resp_valid with resp_error=0; req_ready back after resp_ready.
- 4-beat burst with stalls: len=3, arready delayed 3 cycles, data_queue_ready toggling 1,0,1,0 -> arvalid held 4 cycles with stable fields; exactly 4 pushes in order D0..D3; rready never high while queue not ready; error=0.
- Response backpressure: resp_ready low for 5 cycles -> resp_valid and resp_error stable; req_valid asserted meanwhile is not accepted.
- Errors: (a) beat 2 of 4 with rresp=2'b10; (b) rlast on beat 1 of len=3; (c) rid=5 with AXI_ID=0 -> each yields resp_error=1, and all beats up to and including rlast are pushed.
- Max length: len=255 with continuous rvalid/ready -> 256 pushes, counter wraps-free, rlast on beat 255, error=0.
- Reset mid-burst: rst asserted after 2 of 8 beats -> next cycle all outputs at reset values; a new request then completes cleanly with error=0.
